// File: rtl/ternary_pkg.sv
// Shared ternary types for the register-file datapath: 2-bit trit encoding,
// trit constants and the R0/invalid-address test used by writeback.
package ternary_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t T_ZERO    = 2'b00;
   localparam trit_t T_POS_ONE = 2'b01;
   localparam trit_t T_NEG_ONE = 2'b10;

   localparam int unsigned WB_ADDR_TRITS = 2;

   function automatic logic trit_is_valid(input trit_t t);
      return t != 2'b11;
   endfunction

   // An address with any unencodable trit is folded onto R0 so it can never write.
   function automatic logic trit2_is_r0(input trit_t [WB_ADDR_TRITS-1:0] a);
      return !trit_is_valid(a[1]) || !trit_is_valid(a[0]) ||
             ((a[1] == T_ZERO) && (a[0] == T_ZERO));
   endfunction

endpackage

// File: rtl/ternary_wb_fifo.sv
// Load-result queue for the writeback arbiter: synchronous FIFO of (addr, data)
// entries, exposing per-entry address/valid so hazards can be queried.
module ternary_wb_fifo
   import ternary_pkg::*;
#(
   parameter  int DEPTH      = 2,
   parameter  int TRIT_WIDTH = 27,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_push,
   input  trit_t [1:0]                      i_push_addr,
   input  trit_t [TRIT_WIDTH-1:0]           i_push_data,
   input  logic                             i_pop,
   output trit_t [1:0]                      o_head_addr,
   output trit_t [TRIT_WIDTH-1:0]           o_head_data,
   output logic  [CNT_W-1:0]                o_count,
   output logic                             o_full,
   output logic                             o_empty,
   output logic  [DEPTH-1:0]                o_entry_valid,
   output trit_t [DEPTH-1:0][1:0]           o_entry_addr
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic  [PTR_W-1:0]      r_wr_ptr;
   logic  [PTR_W-1:0]      r_rd_ptr;
   logic  [CNT_W-1:0]      r_count;
   logic  [DEPTH-1:0]      r_valid;
   trit_t [1:0]            r_mem_addr [DEPTH];
   trit_t [TRIT_WIDTH-1:0] r_mem_data [DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (i_pop) begin
            r_rd_ptr           <= ptr_inc(r_rd_ptr);
            r_valid[r_rd_ptr]  <= 1'b0;
         end
         if (i_push) begin
            r_wr_ptr           <= ptr_inc(r_wr_ptr);
            r_valid[r_wr_ptr]  <= 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage carries no reset; r_valid and r_count gate every use of it.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem_addr[r_wr_ptr] <= i_push_addr;
         r_mem_data[r_wr_ptr] <= i_push_data;
      end
   end

   assign o_head_addr   = r_mem_addr[r_rd_ptr];
   assign o_head_data   = r_mem_data[r_rd_ptr];
   assign o_count       = r_count;
   assign o_full        = (r_count == CNT_W'(DEPTH));
   assign o_empty       = (r_count == '0);
   assign o_entry_valid = r_valid;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         o_entry_addr[i] = r_mem_addr[i];
      end
   end

endmodule

// File: rtl/ternary_writeback_arbiter.sv
// Writeback stage owning the ternary register file's single write port: merges
// the fixed-latency ALU path with queued load results, with anti-starvation.
module ternary_writeback_arbiter
   import ternary_pkg::*;
#(
   parameter  int TRIT_WIDTH   = 27,
   parameter  int DEPTH        = 2,
   parameter  int STARVE_LIMIT = 4,
   localparam int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   input  trit_t [1:0]            alu_rd_addr,
   input  trit_t [TRIT_WIDTH-1:0] alu_data,
   output logic                   alu_stall,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  trit_t [1:0]            mem_rd_addr,
   input  trit_t [TRIT_WIDTH-1:0] mem_data,
   output logic                   rf_we,
   output trit_t [1:0]            rf_rd_addr,
   output trit_t [TRIT_WIDTH-1:0] rf_rd_data,
   input  trit_t [1:0]            hz_addr,
   output logic                   hz_pending,
   output logic  [CNT_W-1:0]      fifo_count
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic                   r_alu_stall;
   logic [SW-1:0]          r_starve;

   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   trit_t [1:0]            w_head_addr;
   trit_t [TRIT_WIDTH-1:0] w_head_data;
   logic  [DEPTH-1:0]      w_entry_valid;
   trit_t [DEPTH-1:0][1:0] w_entry_addr;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_alu_grant;
   logic                   w_starve_hit;
   logic                   w_hz;

   ternary_wb_fifo #(
      .DEPTH      (DEPTH),
      .TRIT_WIDTH (TRIT_WIDTH)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_push        (w_push),
      .i_push_addr   (mem_rd_addr),
      .i_push_data   (mem_data),
      .i_pop         (w_pop),
      .o_head_addr   (w_head_addr),
      .o_head_data   (w_head_data),
      .o_count       (fifo_count),
      .o_full        (w_fifo_full),
      .o_empty       (w_fifo_empty),
      .o_entry_valid (w_entry_valid),
      .o_entry_addr  (w_entry_addr)
   );

   // R0 loads complete the handshake but are dropped rather than queued.
   assign mem_ready    = rst_n && !w_fifo_full;
   assign w_push       = mem_valid && mem_ready && !trit2_is_r0(mem_rd_addr);
   assign w_alu_grant  = !r_alu_stall && alu_valid && !trit2_is_r0(alu_rd_addr);
   assign w_pop        = !w_alu_grant && !w_fifo_empty;
   assign w_starve_hit = w_alu_grant && !w_fifo_empty &&
                         (r_starve == SW'(STARVE_LIMIT - 1));
   assign alu_stall    = r_alu_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we       <= 1'b0;
         rf_rd_addr  <= {T_ZERO, T_ZERO};
         rf_rd_data  <= {TRIT_WIDTH{T_ZERO}};
         r_alu_stall <= 1'b0;
         r_starve    <= '0;
      end else begin
         rf_we       <= w_alu_grant || w_pop;
         r_alu_stall <= w_starve_hit;
         if (w_alu_grant) begin
            rf_rd_addr <= alu_rd_addr;
            rf_rd_data <= alu_data;
         end else if (w_pop) begin
            rf_rd_addr <= w_head_addr;
            rf_rd_data <= w_head_data;
         end
         // Counter peaks at STARVE_LIMIT; the forced pop that follows clears it.
         if (w_pop || w_fifo_empty) begin
            r_starve <= '0;
         end else if (w_alu_grant) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end

   // NOTE: default assigned first so this combinational block cannot infer a latch.
   always_comb begin
      w_hz = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_entry_valid[i] && (w_entry_addr[i] == hz_addr)) begin
            w_hz = 1'b1;
         end
      end
      if (trit2_is_r0(hz_addr)) begin
         w_hz = 1'b0;
      end
   end

   assign hz_pending = w_hz;

endmodule
